icache: RTL and testbench

Direct-mapped, read-only instruction cache between the `cpu` fetch port and the block-wide instruction memory. It returns `INST` for the current `PC` in the same cycle on a hit. On a miss it asserts `ICACHE_BUSY`, which stalls the PC update, and fetches the whole 16-byte block. It is the upstream counterpart of `dcache` and shares its IDLE / MEM_READ / UPDATE miss flow.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_line_store.sv | 52 +++++
 rtl/icache.sv | 113 +++++++++++
 tb/tb_icache.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and address-field constants for the instruction cache.
// Contents: FSM state encoding, field widths and the bit positions used to split a fetch PC
// into tag / index / word offset.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    localparam int TAG_W     = 3;
    localparam int INDEX_W   = 3;
    localparam int OFFSET_W  = 2;
    localparam int BLOCK_W   = 128;
    localparam int WORD_W    = 32;
    localparam int BLKADDR_W = TAG_W + INDEX_W;

    // Field positions inside the byte address.
    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;  // 4
    localparam int TAG_LSB    = INDEX_LSB + INDEX_W;    // 7
    localparam int RANGE_LSB  = TAG_LSB + TAG_W;        // 10: bits above this must be zero

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: valid / tag / data arrays of the direct-mapped instruction cache.
// Ports:
//   clk, rst      clock and asynchronous active-high reset (clears all valid bits)
//   index, tag    line select and tag to compare
//   offset        word within the line
//   write         load wdata / tag into line `index` and mark it valid
//   wdata         full block from memory, word 0 in the low 32 bits
//   hit           line valid and tag equal (combinational)
//   word          selected word of the indexed line (combinational)
module icache_line_store
    import icache_pkg::*;
#(
    parameter int BLOCKS = 8,
    parameter int WORDS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  index,
    input  logic [TAG_W-1:0]    tag,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                write,
    input  logic [BLOCK_W-1:0]  wdata,
    output logic                hit,
    output logic [WORD_W-1:0]   word
);

    logic [BLOCKS-1:0]                valid;
    logic [TAG_W-1:0]                 tags [BLOCKS];
    logic [WORDS-1:0][WORD_W-1:0]     data [BLOCKS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (write) begin
            valid[index] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (write) begin
            tags[index] <= tag;
            data[index] <= wdata;
        end
    end

    always_comb begin
        hit  = valid[index] && (tags[index] == tag);
        word = data[index][offset];
    end

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache in front of a block-wide instruction memory.
// Optional feature macro: ICACHE_STATS_EN adds saturating hit_count / miss_count outputs.
// Ports:
//   CLK, RESET     clock and asynchronous active-high reset
//   PC             fetch byte address; addresses with PC[31:10] != 0 are ignored
//   INST           instruction for PC on a hit, otherwise holds its previous value
//   ICACHE_BUSY    high while a miss is outstanding (stalls the PC)
//   mem_read       block read request to instruction memory
//   mem_address    block address PC[9:4], captured when the read starts
//   mem_readdata   returned 128-bit block, word 0 in [31:0]
//   mem_busywait   memory busy; block valid once it falls
//   hit_count, miss_count (ICACHE_STATS_EN only) saturating 16-bit event counters
module icache
    import icache_pkg::*;
#(
    parameter int BLOCKS = 8,
    parameter int WORDS  = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          PC,
    output logic [WORD_W-1:0]    INST,
    output logic                 ICACHE_BUSY,
    output logic                 mem_read,
    output logic [BLKADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]   mem_readdata,
    input  logic                 mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
`endif
);

    state_t             state;
    logic               in_range;
    logic               hit;
    logic               miss;
    logic [WORD_W-1:0]  word;
    logic [WORD_W-1:0]  inst_q;
    logic               unused_pc_bits;

    icache_line_store #(
        .BLOCKS (BLOCKS),
        .WORDS  (WORDS)
    ) u_store (
        .clk    (CLK),
        .rst    (RESET),
        .index  (PC[INDEX_LSB +: INDEX_W]),
        .tag    (PC[TAG_LSB +: TAG_W]),
        .offset (PC[OFFSET_LSB +: OFFSET_W]),
        .write  (state == UPDATE),
        .wdata  (mem_readdata),
        .hit    (hit),
        .word   (word)
    );

    always_comb begin
        in_range       = (PC[31:RANGE_LSB] == '0);
        miss           = in_range && !hit;
        unused_pc_bits = ^PC[OFFSET_LSB-1:0];
        // A hit forwards the word straight through; otherwise the last returned value holds.
        INST           = (in_range && hit) ? word : inst_q;
        // Gated with RESET so the stall drops at once when a miss is aborted by reset.
        ICACHE_BUSY    = !RESET && ((state != IDLE) || miss);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_address <= '0;
            inst_q      <= '0;
`ifdef ICACHE_STATS_EN
            hit_count   <= '0;
            miss_count  <= '0;
`endif
        end else begin
            inst_q <= INST;
            case (state)
                IDLE: begin
                    if (miss) begin
                        state       <= MEM_READ;
                        mem_read    <= 1'b1;
                        mem_address <= PC[INDEX_LSB +: BLKADDR_W];
`ifdef ICACHE_STATS_EN
                        if (miss_count != '1) miss_count <= miss_count + 16'd1;
`endif
                    end
`ifdef ICACHE_STATS_EN
                    else if (in_range && hit_count != '1) begin
                        hit_count <= hit_count + 16'd1;
                    end
`endif
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        state    <= UPDATE;
                        mem_read <= 1'b0;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    mem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed bench for icache with a cycle-level behavioural reference model.
// Memory returns, for block address b, words equal to their own byte address (b*16 + 4*i),
// so every hit must return the PC with its low two bits cleared.
module tb_icache;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [31:0]  PC = 32'hFFFF_FFFC;
    logic [31:0]  INST;
    logic         ICACHE_BUSY;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    icache #(.BLOCKS(8), .WORDS(4)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INST         (INST),
        .ICACHE_BUSY  (ICACHE_BUSY),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int lat    = 5;   // memory busy edges per block read

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory ----------------
    logic       mem_prev_read = 1'b0;
    logic [5:0] mem_blk = '0;
    int         mem_cnt = 0;

    initial begin
        forever begin
            @(negedge CLK);
            if (mem_read && !mem_prev_read) begin
                mem_blk      = mem_address;
                mem_cnt      = lat;
                mem_busywait = 1'b1;
            end else if (mem_busywait) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_busywait = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        logic [31:0] ii;
                        ii = i;
                        mem_readdata[32*i +: 32] = {22'd0, mem_blk, ii[1:0], 2'b00};
                    end
                end
            end
            mem_prev_read = mem_read;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // A miss is described as a countdown k of falling edges since the miss was first seen:
    // k=0 request not yet issued, 1..lat+1 memory read outstanding, lat+2 line being written,
    // and the access hits on the following cycle.
    bit          mvalid [8];
    logic [2:0]  mtag   [8];
    int          miss_k = -1;
    logic [31:0] last_inst = '0;
    int          mhit = 0;
    int          mmiss = 0;
    logic        prev_busy = 1'b0;
    logic [31:0] prev_pc = '0;

    initial begin
        forever begin
            @(negedge CLK);
            if (RESET) begin
                for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
                miss_k    = -1;
                last_inst = '0;
                mhit      = 0;
                mmiss     = 0;
                prev_busy = 1'b0;
            end else begin
                logic [2:0]  idx;
                logic [2:0]  tg;
                logic [31:0] exp_inst;
                idx = PC[6:4];
                tg  = PC[9:7];
`ifdef ICACHE_STATS_EN
                chk("hit_count", 32'(hit_count), 32'(mhit));
                chk("miss_count", 32'(miss_count), 32'(mmiss));
`endif
                if (prev_busy) chk("pc_stable_while_busy", PC, prev_pc);
                if (PC[31:10] != 22'd0) begin
                    chk("oor_busy", 32'(ICACHE_BUSY), 32'd0);
                    chk("oor_mem_read", 32'(mem_read), 32'd0);
                    chk("oor_inst_hold", INST, last_inst);
                end else if (miss_k < 0 && mvalid[idx] && mtag[idx] == tg) begin
                    exp_inst = {PC[31:2], 2'b00};
                    chk("hit_busy", 32'(ICACHE_BUSY), 32'd0);
                    chk("hit_mem_read", 32'(mem_read), 32'd0);
                    chk("hit_inst", INST, exp_inst);
                    last_inst = exp_inst;
                    mhit++;
                end else begin
                    if (miss_k < 0) begin
                        miss_k = 0;
                        mmiss++;
                    end
                    chk("miss_busy", 32'(ICACHE_BUSY), 32'd1);
                    chk("miss_mem_read", 32'(mem_read), 32'(miss_k >= 1 && miss_k <= lat + 1));
                    if (miss_k >= 1 && miss_k <= lat + 1)
                        chk("miss_mem_address", 32'(mem_address), 32'(PC[9:4]));
                    chk("miss_inst_hold", INST, last_inst);
                    if (miss_k == lat + 2) begin
                        mvalid[idx] = 1'b1;
                        mtag[idx]   = tg;
                        miss_k      = -1;
                    end else begin
                        miss_k++;
                    end
                end
                prev_busy = ICACHE_BUSY;
                prev_pc   = PC;
            end
        end
    end

    // ---------------- cpu side ----------------
    // Counts falling edges with ICACHE_BUSY high and with mem_read high until the fetch is served.
    task automatic wait_done(output int busy_cycles, output int rd_cycles);
        bit done;
        done = 1'b0;
        busy_cycles = 0;
        rd_cycles = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge CLK);
            if (mem_read) rd_cycles++;
            if (!ICACHE_BUSY) done = 1'b1;
            else busy_cycles++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: busy still %b after 100 cycles, required 0", ICACHE_BUSY);
        end
    endtask

    task automatic fetch(input logic [31:0] addr, output int busy_cycles, output int rd_cycles);
        @(posedge CLK);
        #1 PC = addr;
        wait_done(busy_cycles, rd_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int r;

        // Reset with the post-reset out-of-range PC.
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("reset_busy", 32'(ICACHE_BUSY), 32'd0);
        chk("reset_mem_read", 32'(mem_read), 32'd0);
        chk("reset_mem_address", 32'(mem_address), 32'd0);
        chk("reset_inst", INST, 32'h0);

        // Cold miss at PC=0, memory busy for 5 edges.
        fetch(32'h0, b, r);
        chk("cold_mem_read_cycles", 32'(r), 32'd6);
        chk("cold_stall_after_request", 32'(b - 1), 32'd7);
        chk("cold_inst", INST, 32'h0);

        // Remaining words of the filled line hit with no stall.
        for (int a = 4; a <= 12; a += 4) begin
            fetch(32'(a), b, r);
            chk("line_hit_busy_cycles", 32'(b), 32'd0);
            chk("line_hit_inst", INST, 32'(a));
        end

        // Same index, different tag: replace, then the original misses again.
        fetch(32'h080, b, r);
        chk("replace_busy_cycles", 32'(b), 32'd8);
        chk("replace_inst", INST, 32'h080);
        fetch(32'h0, b, r);
        chk("refetch_busy_cycles", 32'(b), 32'd8);
        chk("refetch_inst", INST, 32'h0);

        // Reset during the 3rd MEM_READ cycle of a miss.
        @(posedge CLK);
        #1 PC = 32'h040;
        repeat (4) @(negedge CLK);
        chk("abort_pre_mem_read", 32'(mem_read), 32'd1);
        #2 RESET = 1'b1;
        #1;
        chk("abort_mem_read", 32'(mem_read), 32'd0);
        chk("abort_busy", 32'(ICACHE_BUSY), 32'd0);
        chk("abort_inst", INST, 32'h0);
        PC = 32'h0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        wait_done(b, r);
        chk("post_reset_miss_cycles", 32'(b), 32'd8);
        chk("post_reset_inst", INST, 32'h0);

        // Ten sequential fetches from a clean cache: 3 misses, 10 hits.
        @(posedge CLK);
        #1 RESET = 1'b1;
        PC = 32'hFFFF_FFFC;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        for (int i = 0; i < 10; i++) fetch(32'(i * 4), b, r);
        @(posedge CLK);
        #1 PC = 32'hFFFF_FFFC;
        repeat (2) @(negedge CLK);
        chk("oor_inst_holds_last", INST, 32'h24);
        chk("oor_busy_final", 32'(ICACHE_BUSY), 32'd0);
`ifdef ICACHE_STATS_EN
        chk("stats_miss_count", 32'(miss_count), 32'd3);
        chk("stats_hit_count", 32'(hit_count), 32'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
